// File: rtl/icache_fill_if.sv
// Word-read bus between the instruction cache and backing memory.
// The cache is the master: it drives the request and address, and memory answers with ready and data.
interface icache_fill_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (output mem_req, mem_addr, input mem_ready, mem_rdata);
  modport slave  (input mem_req, mem_addr, output mem_ready, mem_rdata);
endinterface

// File: rtl/icache_fill.sv
// Direct-mapped instruction cache with zero-latency lookup.
// A miss refills the whole line one word at a time over the memory handshake.
module icache_fill #(
  parameter int unsigned LINES          = 16,
  parameter int unsigned WORDS_PER_LINE = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [31:0]   pc,
  input  logic          invalidate,
  output logic [31:0]   instr,
  output logic          hit,
  output logic [31:0]   miss_count,
  icache_fill_if.master mem
);
  localparam int unsigned OFF_W = $clog2(WORDS_PER_LINE);
  localparam int unsigned IDX_W = $clog2(LINES);
  localparam int unsigned TAG_W = 30 - OFF_W - IDX_W;
  localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(WORDS_PER_LINE - 1);

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_e;

  state_e              state_q, state_d;
  logic [LINES-1:0]    valid_q;
  logic [TAG_W-1:0]    tag_q  [LINES];
  logic [31:0]         data_q [LINES][WORDS_PER_LINE];
  logic [TAG_W-1:0]    fill_tag_q, fill_tag_d;
  logic [IDX_W-1:0]    fill_idx_q, fill_idx_d;
  logic [OFF_W-1:0]    cnt_q, cnt_d;
  logic                pend_q, pend_d;
  logic                req_q, req_d;
  logic [31:0]         addr_q, addr_d;
  logic [31:0]         miss_q, miss_d;
  logic                start_fill, word_we, line_done, set_valid;

  logic [OFF_W-1:0]    pc_off;
  logic [IDX_W-1:0]    pc_idx;
  logic [TAG_W-1:0]    pc_tag;
  logic [1:0]          unused_pc_byte;

  assign pc_off         = pc[OFF_W+1:2];
  assign pc_idx         = pc[IDX_W+OFF_W+1:OFF_W+2];
  assign pc_tag         = pc[31:IDX_W+OFF_W+2];
  assign unused_pc_byte = pc[1:0];

  assign hit          = (state_q == IDLE) && valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);
  assign instr        = hit ? data_q[pc_idx][pc_off] : '0;
  assign mem.mem_req  = req_q;
  assign mem.mem_addr = addr_q;
  assign miss_count   = miss_q;

  always_comb begin
    state_d    = state_q;
    fill_tag_d = fill_tag_q;
    fill_idx_d = fill_idx_q;
    cnt_d      = cnt_q;
    pend_d     = pend_q;
    req_d      = req_q;
    addr_d     = addr_q;
    miss_d     = miss_q;
    start_fill = 1'b0;
    word_we    = 1'b0;
    line_done  = 1'b0;
    set_valid  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!hit && !invalidate) begin
          start_fill = 1'b1;
          state_d    = FILL;
          fill_tag_d = pc_tag;
          fill_idx_d = pc_idx;
          cnt_d      = '0;
          req_d      = 1'b1;
          addr_d     = {pc_tag, pc_idx, {OFF_W{1'b0}}, 2'b00};
          if (miss_q != '1) miss_d = miss_q + 32'd1;
        end
      end
      FILL: begin
        if (invalidate) pend_d = 1'b1;
        if (mem.mem_ready) begin
          word_we = 1'b1;
          cnt_d   = cnt_q + OFF_W'(1);
          if (cnt_q == LAST_WORD) begin
            req_d   = 1'b0;
            state_d = DONE;
          end else begin
            addr_d = {fill_tag_q, fill_idx_q, cnt_d, 2'b00};
          end
        end
      end
      DONE: begin
        line_done = 1'b1;
        // An invalidate landing on the DONE cycle itself must also keep the line invalid.
        set_valid = !pend_q && !invalidate;
        pend_d    = 1'b0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      fill_tag_q <= '0;
      fill_idx_q <= '0;
      cnt_q      <= '0;
      pend_q     <= 1'b0;
      req_q      <= 1'b0;
      addr_q     <= '0;
      miss_q     <= '0;
    end else begin
      state_q    <= state_d;
      fill_tag_q <= fill_tag_d;
      fill_idx_q <= fill_idx_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      req_q      <= req_d;
      addr_q     <= addr_d;
      miss_q     <= miss_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || invalidate) begin
      valid_q <= '0;
    end else begin
      if (start_fill) valid_q[pc_idx]     <= 1'b0;
      if (set_valid)  valid_q[fill_idx_q] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && word_we)   data_q[fill_idx_q][cnt_q] <= mem.mem_rdata;
    if (!reset && line_done) tag_q[fill_idx_q]         <= fill_tag_q;
  end
endmodule
